// File: rtl/matrix_input_handler_pkg.sv
// Shared definitions for the matrix input handler: task-mode encodings,
// FSM state encoding, delimiter bytes, default limits and the LFSR seed.
package matrix_input_handler_pkg;

  typedef enum logic [1:0] {
    MODE_STORE = 2'd0,
    MODE_DIMS  = 2'd1,
    MODE_ID    = 2'd2,
    MODE_BAD   = 2'd3
  } task_mode_e;

  typedef enum logic [3:0] {
    S_IDLE, S_GET_M, S_GET_N, S_CHK_DIM, S_WAIT_ADDR, S_WR_M,
    S_WR_N, S_ELEM, S_DONE, S_GET_ID, S_HOLD, S_ERR
  } state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  localparam int DEF_MAX_DIM = 5;
  localparam int DEF_MAX_VAL = 9;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic logic is_delim(input logic [7:0] b);
    return (b == CH_SPACE) || (b == CH_CR) || (b == CH_LF);
  endfunction

endpackage

// File: rtl/matrix_input_handler_if.sv
// Controller <-> input-handler bundle: task control, base-address handshake,
// UART RX byte stream, parsed results and the matrix RAM write port.
//   master: controller/stimulus side (drives en, task_mode, rx_*, addr_*)
//   slave : the input handler (drives dims/id/status and mem_*)
interface matrix_input_handler_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              en;
  logic [1:0]        task_mode;
  logic              is_gen_mode;
  logic              addr_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              dims_valid;
  logic [31:0]       dim_m;
  logic [31:0]       dim_n;
  logic              id_valid;
  logic [31:0]       id_val;
  logic              rx_done;
  logic              error_flag;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output en, task_mode, is_gen_mode, addr_ready, base_addr, rx_data, rx_valid,
    input  dims_valid, dim_m, dim_n, id_valid, id_val, rx_done, error_flag,
           mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  en, task_mode, is_gen_mode, addr_ready, base_addr, rx_data, rx_valid,
    output dims_valid, dim_m, dim_n, id_valid, id_val, rx_done, error_flag,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/matrix_input_handler_ascii_num_parser.sv
// ASCII decimal tokenizer.
//   clk, rst       : clock, synchronous active-high reset
//   clr            : discard any partial token
//   rx_data/valid  : incoming byte and its strobe
//   tok_valid      : a delimiter closed a token this cycle (combinational)
//   tok_val        : value of the token being closed
//   tok_err        : illegal byte, or the value would exceed 999
module ascii_num_parser
  import matrix_input_handler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        tok_valid,
  output logic [31:0] tok_val,
  output logic        tok_err
);
  logic [9:0]  acc;
  logic        have_digit;
  logic        digit;
  logic        delim;
  logic [13:0] acc_next;
  logic        ovf;

  always_comb begin
    digit     = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    delim     = is_delim(rx_data);
    acc_next  = 14'(acc) * 14'd10 + {10'b0, rx_data[3:0]};
    ovf       = acc_next > 14'd999;
    tok_valid = rx_valid && delim && have_digit;
    tok_err   = rx_valid && ((!digit && !delim) || (digit && ovf));
    tok_val   = 32'(acc);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc        <= '0;
      have_digit <= 1'b0;
    end else if (rx_valid) begin
      if (digit && !ovf) begin
        acc        <= acc_next[9:0];
        have_digit <= 1'b1;
      end else if (tok_valid) begin
        acc        <= '0;
        have_digit <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/matrix_input_handler.sv
// Responder side of the controller/input handshake. Parses m, n, elements
// or an ID from the UART byte stream and stores matrices into RAM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of matrix_input_handler_if (control, RX, results, RAM port)
//
// state     | meaning
// IDLE      | waiting for en to rise
// GET_M     | parsing row count
// GET_N     | parsing column count
// CHK_DIM   | range check of m and n
// WAIT_ADDR | dims_valid high, waiting for addr_ready
// WR_M      | write m at base
// WR_N      | write n at base+1, load element counter
// ELEM      | write elements (UART tokens or LFSR)
// DONE      | rx_done pulse
// GET_ID    | parsing an ID
// HOLD      | dims_valid/id_valid held until en falls
// ERR       | error_flag held until en falls
module matrix_input_handler
  import matrix_input_handler_pkg::*;
#(
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int MAX_VAL = DEF_MAX_VAL,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input logic clk,
  input logic rst,
  matrix_input_handler_if.slave bus
);
  localparam logic [31:0] MAX_DIM_U = MAX_DIM;
  localparam logic [31:0] MAX_VAL_U = MAX_VAL;

  state_e            state, state_next;
  task_mode_e        mode_q;
  logic              gen_q, en_q;
  logic [31:0]       dim_m_q, dim_n_q, id_q;
  logic [ADDR_W-1:0] wr_addr, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, wr_data;
  logic              mem_we_q, wr_en;
  logic [7:0]        elem_left, lfsr, lfsr_mod;
  logic              lfsr_fb, dims_bad;
  logic              parse_on, tok_valid, tok_err;
  logic [31:0]       tok_val;
  logic              ld_mode, ld_m, ld_n, ld_id, ld_base, ld_cnt, adv_lfsr;

  // Parser sees bytes only while a token is expected; elsewhere it is held clear.
  assign parse_on = bus.en && (state == S_GET_M || state == S_GET_N || state == S_GET_ID ||
                               (state == S_ELEM && !gen_q));

  ascii_num_parser u_parser (
    .clk       (clk),
    .rst       (rst),
    .clr       (!parse_on),
    .rx_data   (bus.rx_data),
    .rx_valid  (bus.rx_valid && parse_on),
    .tok_valid (tok_valid),
    .tok_val   (tok_val),
    .tok_err   (tok_err)
  );

  assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign lfsr_mod = 8'(lfsr % 8'(MAX_VAL + 1));
  assign dims_bad = (dim_m_q == '0) || (dim_m_q > MAX_DIM_U) ||
                    (dim_n_q == '0) || (dim_n_q > MAX_DIM_U);

  always_comb begin
    state_next = state;
    ld_mode    = 1'b0;
    ld_m       = 1'b0;
    ld_n       = 1'b0;
    ld_id      = 1'b0;
    ld_base    = 1'b0;
    ld_cnt     = 1'b0;
    adv_lfsr   = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    if (!bus.en) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (!en_q) begin
          ld_mode = 1'b1;
          case (task_mode_e'(bus.task_mode))
            MODE_STORE, MODE_DIMS: state_next = S_GET_M;
            MODE_ID:               state_next = S_GET_ID;
            default:               state_next = S_ERR;
          endcase
        end
        S_GET_M: if (tok_err) state_next = S_ERR;
                 else if (tok_valid) begin ld_m = 1'b1; state_next = S_GET_N; end
        S_GET_N: if (tok_err) state_next = S_ERR;
                 else if (tok_valid) begin ld_n = 1'b1; state_next = S_CHK_DIM; end
        S_CHK_DIM: if (dims_bad) state_next = S_ERR;
                   else state_next = (mode_q == MODE_STORE) ? S_WAIT_ADDR : S_HOLD;
        S_WAIT_ADDR: if (bus.addr_ready) begin ld_base = 1'b1; state_next = S_WR_M; end
        S_WR_M: begin
          wr_en = 1'b1; wr_data = dim_m_q[DATA_W-1:0]; state_next = S_WR_N;
        end
        S_WR_N: begin
          wr_en = 1'b1; wr_data = dim_n_q[DATA_W-1:0]; ld_cnt = 1'b1; state_next = S_ELEM;
        end
        S_ELEM: if (gen_q) begin
          wr_en = 1'b1; wr_data = DATA_W'(lfsr_mod); adv_lfsr = 1'b1;
          if (elem_left == 8'd1) state_next = S_DONE;
        end else if (tok_err || (tok_valid && tok_val > MAX_VAL_U)) begin
          state_next = S_ERR;
        end else if (tok_valid) begin
          wr_en = 1'b1; wr_data = tok_val[DATA_W-1:0];
          if (elem_left == 8'd1) state_next = S_DONE;
        end
        S_DONE: state_next = S_IDLE;
        S_GET_ID: if (tok_err) state_next = S_ERR;
                  else if (tok_valid) begin ld_id = 1'b1; state_next = S_HOLD; end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      en_q        <= 1'b0;
      mode_q      <= MODE_STORE;
      gen_q       <= 1'b0;
      dim_m_q     <= '0;
      dim_n_q     <= '0;
      id_q        <= '0;
      wr_addr     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      elem_left   <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      state    <= state_next;
      en_q     <= bus.en;
      mem_we_q <= wr_en;
      if (wr_en) begin
        mem_addr_q  <= wr_addr;
        mem_wdata_q <= wr_data;
        wr_addr     <= wr_addr + ADDR_W'(1);
      end else if (ld_base) begin
        wr_addr <= bus.base_addr;
      end
      if (ld_mode) begin
        mode_q <= task_mode_e'(bus.task_mode);
        gen_q  <= bus.is_gen_mode;
      end
      if (!bus.en) begin
        dim_m_q <= '0;
        dim_n_q <= '0;
        id_q    <= '0;
      end else begin
        if (ld_m)  dim_m_q <= tok_val;
        if (ld_n)  dim_n_q <= tok_val;
        if (ld_id) id_q    <= tok_val;
      end
      // Down-counter of remaining elements; terminal count is 1 on the last write.
      if (ld_cnt) elem_left <= {4'b0, dim_m_q[3:0]} * {4'b0, dim_n_q[3:0]};
      else if (wr_en && state == S_ELEM) elem_left <= elem_left - 8'd1;
      if (adv_lfsr) lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  assign bus.dims_valid = (state == S_WAIT_ADDR) || (state == S_HOLD && mode_q == MODE_DIMS);
  assign bus.id_valid   = (state == S_HOLD) && (mode_q == MODE_ID);
  assign bus.error_flag = (state == S_ERR);
  assign bus.rx_done    = (state == S_DONE);
  assign bus.dim_m      = dim_m_q;
  assign bus.dim_n      = dim_n_q;
  assign bus.id_val     = id_q;
  // A registered write still in flight is suppressed the moment en drops.
  assign bus.mem_we     = mem_we_q && bus.en;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_matrix_input_handler.sv
module tb_matrix_input_handler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_input_handler_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  matrix_input_handler #(.MAX_DIM(5), .MAX_VAL(9), .ADDR_W(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  wr_t log_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) log_q.push_back('{bus.mem_addr, bus.mem_wdata, cyc});
    if (bus.rx_done === 1'b1) done_cnt++;
  end

  task send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data = b; bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task start_task(input logic [1:0] m, input logic g);
    @(posedge clk); #1;
    bus.task_mode = m; bus.is_gen_mode = g; bus.en = 1'b1;
    log_q.delete(); done_cnt = 0;
  endtask

  task stop_task;
    @(posedge clk); #1; bus.en = 1'b0;
    @(posedge clk); #1;
  endtask

  task pulse_addr(input logic [7:0] b);
    @(posedge clk); #1;
    bus.base_addr = b; bus.addr_ready = 1'b1;
    @(posedge clk); #1;
    bus.addr_ready = 1'b0;
  endtask

  task wait_level(input int which, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = bus.dims_valid;
        1:       seen = bus.id_valid;
        default: seen = bus.error_flag;
      endcase
    end
  endtask

  task pad_log(input int n);
    while (log_q.size() < n) log_q.push_back('{8'hxx, 8'hxx, -1});
  endtask

  task test_reset;
    rst = 1'b1; bus.en = 1'b0; bus.task_mode = 2'd0; bus.is_gen_mode = 1'b0;
    bus.addr_ready = 1'b0; bus.base_addr = 8'h00; bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.dims_valid, bus.id_valid, bus.rx_done, bus.error_flag, bus.mem_we} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000",
        {bus.dims_valid, bus.id_valid, bus.rx_done, bus.error_flag, bus.mem_we});
    end
    n_cmp++;
    if ({bus.dim_m, bus.dim_n, bus.id_val} !== 96'd0) begin
      n_bad++; $display("FAIL reset_values: got m=%0d n=%0d id=%0d expected 0", bus.dim_m, bus.dim_n, bus.id_val);
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata} !== 16'h0) begin
      n_bad++; $display("FAIL reset_mem: got %h/%h expected 00/00", bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task test_store_uart;
    bit seen;
    logic [7:0] ed [8] = '{8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    start_task(2'd0, 1'b0);
    send_str("2 3 ");
    wait_level(0, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_bad++; $display("FAIL t1_dims_valid: got %b expected 1", seen); end
    n_cmp++;
    if (bus.dim_m !== 32'd2 || bus.dim_n !== 32'd3) begin
      n_bad++; $display("FAIL t1_dims: got %0d x %0d expected 2 x 3", bus.dim_m, bus.dim_n);
    end
    pulse_addr(8'h10);
    @(negedge clk);
    n_cmp++;
    if (bus.dims_valid !== 1'b0) begin n_bad++; $display("FAIL t1_dims_drop: got %b expected 0", bus.dims_valid); end
    repeat (2) @(posedge clk);
    send_str("1 2 3 4 5 6\n");
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (log_q.size() !== 8) begin n_bad++; $display("FAIL t1_write_count: got %0d expected 8", log_q.size()); end
    pad_log(8);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (log_q[k].a !== 8'(8'h10 + k) || log_q[k].d !== ed[k]) begin
        n_bad++; $display("FAIL t1_write%0d: got %h:%0d expected %h:%0d", k, log_q[k].a, log_q[k].d, 8'(8'h10 + k), ed[k]);
      end
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL t1_rx_done: got %0d cycles expected 1", done_cnt); end
    stop_task;
  endtask

  task test_store_gen;
    bit seen;
    start_task(2'd0, 1'b1);
    send_str("1 2 ");
    wait_level(0, seen);
    n_cmp++;
    if (seen !== 1'b1 || bus.dim_m !== 32'd1 || bus.dim_n !== 32'd2) begin
      n_bad++; $display("FAIL t2_dims: got v=%b %0d x %0d expected v=1 1 x 2", seen, bus.dim_m, bus.dim_n);
    end
    pulse_addr(8'h00);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (log_q.size() !== 4) begin n_bad++; $display("FAIL t2_write_count: got %0d expected 4", log_q.size()); end
    pad_log(4);
    n_cmp++;
    if (log_q[0].a !== 8'h00 || log_q[0].d !== 8'd1 || log_q[1].a !== 8'h01 || log_q[1].d !== 8'd2) begin
      n_bad++; $display("FAIL t2_header: got %h:%0d %h:%0d expected 00:1 01:2", log_q[0].a, log_q[0].d, log_q[1].a, log_q[1].d);
    end
    n_cmp++;
    if (log_q[2].a !== 8'h02 || log_q[2].d !== 8'd5) begin
      n_bad++; $display("FAIL t2_elem0: got %h:%0d expected 02:5", log_q[2].a, log_q[2].d);
    end
    n_cmp++;
    if (log_q[3].a !== 8'h03 || !(log_q[3].d <= 8'd9)) begin
      n_bad++; $display("FAIL t2_elem1: got %h:%0d expected 03:<=9", log_q[3].a, log_q[3].d);
    end
    n_cmp++;
    if (log_q[3].c !== log_q[2].c + 1) begin
      n_bad++; $display("FAIL t2_consecutive: got cycles %0d,%0d expected adjacent", log_q[2].c, log_q[3].c);
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL t2_rx_done: got %0d cycles expected 1", done_cnt); end
    stop_task;
  endtask

  task test_query_dims;
    bit seen;
    start_task(2'd1, 1'b0);
    send_str("  3 4\r");
    wait_level(0, seen);
    n_cmp++;
    if (seen !== 1'b1 || bus.dim_m !== 32'd3 || bus.dim_n !== 32'd4) begin
      n_bad++; $display("FAIL t3_dims: got v=%b %0d x %0d expected v=1 3 x 4", seen, bus.dim_m, bus.dim_n);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.dims_valid !== 1'b1) begin n_bad++; $display("FAIL t3_hold: got %b expected 1", bus.dims_valid); end
    n_cmp++;
    if (log_q.size() !== 0) begin n_bad++; $display("FAIL t3_no_write: got %0d writes expected 0", log_q.size()); end
    @(posedge clk); #1; bus.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.dims_valid !== 1'b0) begin n_bad++; $display("FAIL t3_en_low: got %b expected 0", bus.dims_valid); end
    n_cmp++;
    start_task(2'd1, 1'b0);
    send_str("5 5 ");
    wait_level(0, seen);
    if (seen !== 1'b1 || bus.error_flag !== 1'b0) begin
      n_bad++; $display("FAIL t3_max_dim: got v=%b err=%b expected v=1 err=0", seen, bus.error_flag);
    end
    stop_task;
  endtask

  task test_select_id;
    bit seen;
    int vals [3] = '{7, 0, 999};
    string strs [3] = '{"7 ", "0 ", "999\n"};
    for (int i = 0; i < 3; i++) begin
      start_task(2'd2, 1'b0);
      send_str(strs[i]);
      wait_level(1, seen);
      n_cmp++;
      if (seen !== 1'b1 || bus.id_val !== 32'(vals[i])) begin
        n_bad++; $display("FAIL t4_id%0d: got v=%b id=%0d expected v=1 id=%0d", i, seen, bus.id_val, vals[i]);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.id_valid !== 1'b1) begin n_bad++; $display("FAIL t4_hold%0d: got %b expected 1", i, bus.id_valid); end
      stop_task;
    end
    start_task(2'd2, 1'b0);
    send_str("1000 ");
    wait_level(2, seen);
    n_cmp++;
    if (seen !== 1'b1 || bus.id_valid !== 1'b0) begin
      n_bad++; $display("FAIL t4_overflow: got err=%b idv=%b expected err=1 idv=0", seen, bus.id_valid);
    end
    stop_task;
  endtask

  task test_errors;
    bit seen;
    start_task(2'd0, 1'b0);
    send_str("6 2 ");
    wait_level(2, seen);
    n_cmp++;
    if (seen !== 1'b1 || bus.dims_valid !== 1'b0) begin
      n_bad++; $display("FAIL t5_big_dim: got err=%b dv=%b expected err=1 dv=0", seen, bus.dims_valid);
    end
    stop_task;
    @(negedge clk);
    n_cmp++;
    if (bus.error_flag !== 1'b0) begin n_bad++; $display("FAIL t5_err_clear: got %b expected 0", bus.error_flag); end
    start_task(2'd1, 1'b0);
    send_str("2a");
    wait_level(2, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_bad++; $display("FAIL t5_bad_char: got %b expected 1", seen); end
    stop_task;
    start_task(2'd1, 1'b0);
    send_str("0 3 ");
    wait_level(2, seen);
    n_cmp++;
    if (seen !== 1'b1 || bus.dims_valid !== 1'b0) begin
      n_bad++; $display("FAIL t5_zero_dim: got err=%b dv=%b expected err=1 dv=0", seen, bus.dims_valid);
    end
    stop_task;
    start_task(2'd3, 1'b0);
    wait_level(2, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_bad++; $display("FAIL t5_mode3: got %b expected 1", seen); end
    stop_task;
    start_task(2'd0, 1'b0);
    send_str("1 1 ");
    wait_level(0, seen);
    pulse_addr(8'h20);
    repeat (2) @(posedge clk);
    send_str("12 ");
    wait_level(2, seen);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (seen !== 1'b1 || log_q.size() !== 2) begin
      n_bad++; $display("FAIL t5_big_elem: got err=%b writes=%0d expected err=1 writes=2", seen, log_q.size());
    end
    stop_task;
  endtask

  task test_abort_restart;
    bit seen;
    bit reached;
    start_task(2'd0, 1'b1);
    send_str("2 2 ");
    wait_level(0, seen);
    pulse_addr(8'h30);
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge clk); #1;
      reached = (log_q.size() >= 4);
    end
    n_cmp++;
    if (reached !== 1'b1) begin n_bad++; $display("FAIL t6_two_elems: got %0d writes expected 4", log_q.size()); end
    @(posedge clk); #1; bus.en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL t6_we_same_cycle: got %b expected 0", bus.mem_we); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_we, bus.dims_valid, bus.error_flag, bus.rx_done} !== 4'b0 || log_q.size() !== 4 || done_cnt !== 0) begin
      n_bad++; $display("FAIL t6_idle: got flags=%b writes=%0d done=%0d expected 0000/4/0",
        {bus.mem_we, bus.dims_valid, bus.error_flag, bus.rx_done}, log_q.size(), done_cnt);
    end
    repeat (2) @(posedge clk);
    start_task(2'd0, 1'b0);
    send_str("1 1 ");
    wait_level(0, seen);
    pulse_addr(8'hFE);
    repeat (2) @(posedge clk);
    send_str("9\n");
    repeat (6) @(posedge clk);
    @(negedge clk);
    pad_log(3);
    n_cmp++;
    if (log_q[0].a !== 8'hFE || log_q[0].d !== 8'd1 || log_q[1].a !== 8'hFF || log_q[1].d !== 8'd1 ||
        log_q[2].a !== 8'h00 || log_q[2].d !== 8'd9) begin
      n_bad++; $display("FAIL t6_restart_wrap: got %h:%0d %h:%0d %h:%0d expected fe:1 ff:1 00:9",
        log_q[0].a, log_q[0].d, log_q[1].a, log_q[1].d, log_q[2].a, log_q[2].d);
    end
    n_cmp++;
    if (done_cnt !== 1 || log_q.size() !== 3) begin
      n_bad++; $display("FAIL t6_restart_done: got done=%0d writes=%0d expected 1/3", done_cnt, log_q.size());
    end
    stop_task;
  endtask

  initial begin
    test_reset();
    test_store_uart();
    test_store_gen();
    test_query_dims();
    test_select_id();
    test_errors();
    test_abort_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
